// File: rtl/ascon_pkg.sv
// Shared types, constants and helpers for the Ascon permutation engine.
package ascon_pkg;

    localparam int AsconMaxRounds = 12;

    // Absolute round index 0..11 (12 is used only as a harmless past-the-end value).
    typedef logic [3:0] rnd_t;

    // x0 occupies the most significant 64 bits; bit 0 of x2 is where the constant lands.
    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } ascon_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perm_fsm_t;

    // Round constant: high nibble counts down from F, low nibble is the index.
    function automatic logic [7:0] ascon_rc(input rnd_t i);
        logic [3:0] hi;
        hi = 4'hF - i;
        return {hi, i};
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, S-box layer, linear diffusion.
module ascon_round
    import ascon_pkg::*;
(
    input  rnd_t         rnd_i,
    input  ascon_state_t state_i,
    output ascon_state_t state_o
);

    logic [63:0] w_a0, w_a1, w_a2, w_a3, w_a4;
    logic [63:0] w_b0, w_b2, w_b4;
    logic [63:0] w_c0, w_c1, w_c2, w_c3, w_c4;
    logic [63:0] w_d0, w_d1, w_d2, w_d3;

    // p_c then bitsliced 5-bit S-box then per-word rotate-xor diffusion.
    always_comb begin
        w_a0 = state_i.x0;
        w_a1 = state_i.x1;
        w_a2 = state_i.x2 ^ {56'd0, ascon_rc(rnd_i)};
        w_a3 = state_i.x3;
        w_a4 = state_i.x4;

        w_b0 = w_a0 ^ w_a4;
        w_b4 = w_a4 ^ w_a3;
        w_b2 = w_a2 ^ w_a1;

        w_c0 = w_b0 ^ (~w_a1 & w_b2);
        w_c1 = w_a1 ^ (~w_b2 & w_a3);
        w_c2 = w_b2 ^ (~w_a3 & w_b4);
        w_c3 = w_a3 ^ (~w_b4 & w_b0);
        w_c4 = w_b4 ^ (~w_b0 & w_a1);

        w_d1 = w_c1 ^ w_c0;
        w_d0 = w_c0 ^ w_c4;
        w_d3 = w_c3 ^ w_c2;
        w_d2 = ~w_c2;

        state_o.x0 = w_d0 ^ rotr64(w_d0, 19) ^ rotr64(w_d0, 28);
        state_o.x1 = w_d1 ^ rotr64(w_d1, 61) ^ rotr64(w_d1, 39);
        state_o.x2 = w_d2 ^ rotr64(w_d2, 1)  ^ rotr64(w_d2, 6);
        state_o.x3 = w_d3 ^ rotr64(w_d3, 10) ^ rotr64(w_d3, 17);
        state_o.x4 = w_c4 ^ rotr64(w_c4, 7)  ^ rotr64(w_c4, 41);
    end

endmodule

// File: rtl/ascon_permutation_engine.sv
// Iterative Ascon-p[nr] engine, 1 or 2 rounds per clock, valid/ready on both sides.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// out_valid_o/state_o stay stable until accepted, in_valid_i is ignored unless idle.
module ascon_permutation_engine
    import ascon_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [3:0]   nr_i,
    input  ascon_state_t state_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output ascon_state_t state_o,
    output logic         busy_o
);

    if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
        $error("ascon_permutation_engine: UNROLL must be 1 or 2");
    end

    localparam rnd_t LastIdx = rnd_t'(AsconMaxRounds);

    perm_fsm_t    r_fsm, w_fsm_d;
    ascon_state_t r_work, r_out;
    rnd_t         r_idx;

    logic [3:0]   w_nr_eff;
    ascon_state_t w_s1, w_next;
    logic         w_two;
    rnd_t         w_step;
    logic         w_last;

    assign w_nr_eff = (nr_i > 4'd12) ? 4'd12 : nr_i;

    ascon_round u_round0 (
        .rnd_i   (r_idx),
        .state_i (r_work),
        .state_o (w_s1)
    );

    if (UNROLL == 2) begin : g_unroll2
        ascon_state_t w_s2;
        rnd_t         w_rem;
        // Second stage; its constant index is past-the-end only when it is bypassed.
        ascon_round u_round1 (
            .rnd_i   (r_idx + 4'd1),
            .state_i (w_s1),
            .state_o (w_s2)
        );
        assign w_rem  = LastIdx - r_idx;
        assign w_two  = (w_rem >= 4'd2);
        assign w_next = w_two ? w_s2 : w_s1;
    end else begin : g_unroll1
        assign w_two  = 1'b0;
        assign w_next = w_s1;
    end

    assign w_step = w_two ? 4'd2 : 4'd1;
    assign w_last = ((r_idx + w_step) == LastIdx);

    assign in_ready_o  = (r_fsm == IDLE);
    assign out_valid_o = (r_fsm == DONE);
    assign busy_o      = (r_fsm == RUN);
    assign state_o     = r_out;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_fsm <= IDLE;
        else         r_fsm <= w_fsm_d;
    end

    // Next-state logic.
    always_comb begin
        w_fsm_d = r_fsm;
        case (r_fsm)
            IDLE:    if (in_valid_i) w_fsm_d = (w_nr_eff == 4'd0) ? DONE : RUN;
            RUN:     if (w_last)     w_fsm_d = DONE;
            DONE:    if (out_ready_i) w_fsm_d = IDLE;
            default: w_fsm_d = IDLE;
        endcase
    end

    // Working state, round index and registered result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_work <= '0;
            r_out  <= '0;
            r_idx  <= '0;
        end else begin
            case (r_fsm)
                IDLE: if (in_valid_i) begin
                    r_work <= state_i;
                    r_idx  <= LastIdx - w_nr_eff;
                    if (w_nr_eff == 4'd0) r_out <= state_i;
                end
                RUN: begin
                    r_work <= w_next;
                    r_idx  <= r_idx + w_step;
                    if (w_last) r_out <= w_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_permutation_engine.sv
// Bench for ascon_permutation_engine: UNROLL=1 and UNROLL=2 instances share one input stream.
module tb_ascon_permutation_engine;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [3:0]   nr_in = '0;
  logic [319:0] st_in = '0;
  logic         out_ready = 1'b0;

  logic         in_ready1, out_valid1, busy1;
  logic         in_ready2, out_valid2, busy2;
  logic [319:0] st_out1, st_out2;

  int checks = 0;
  int errors = 0;
  logic [319:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  ascon_permutation_engine #(.UNROLL(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .nr_i(nr_in), .state_i(st_in), .out_valid_o(out_valid1), .out_ready_i(out_ready),
    .state_o(st_out1), .busy_o(busy1)
  );

  ascon_permutation_engine #(.UNROLL(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready2),
    .nr_i(nr_in), .state_i(st_in), .out_valid_o(out_valid2), .out_ready_i(out_ready),
    .state_o(st_out2), .busy_o(busy2)
  );

  // reference model: S-box as a 32-entry table applied column by column
  function automatic logic [4:0] sbox(input logic [4:0] v);
    logic [4:0] t[32];
    t = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
          5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
          5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
          5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    return t[v];
  endfunction

  function automatic logic [63:0] rot(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] model_perm(input logic [319:0] s, input int nr);
    logic [63:0] x[5];
    int ra[5];
    int rb[5];
    int ne;
    logic [4:0] col, o;
    ra = '{19, 61, 1, 10, 7};
    rb = '{28, 39, 6, 17, 41};
    for (int j = 0; j < 5; j++) x[j] = s[319 - 64*j -: 64];
    ne = (nr > 12) ? 12 : nr;
    for (int i = 12 - ne; i < 12; i++) begin
      x[2] = x[2] ^ 64'((15 - i) * 16 + i);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o = sbox(col);
        for (int j = 0; j < 5; j++) x[j][b] = o[4 - j];
      end
      for (int j = 0; j < 5; j++) x[j] = x[j] ^ rot(x[j], ra[j]) ^ rot(x[j], rb[j]);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] rnd320();
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: one job through both engines, optional backpressure and ignored requests
  task automatic run_job(input logic [3:0] nr, input logic [319:0] st, input int l1,
                         input int l2, input int hold, input bit poke, output logic [319:0] got);
    int n, lat1, lat2;
    logic [319:0] exp;
    exp_q.push_back(model_perm(st, int'(nr)));
    @(negedge clk);
    in_valid = 1'b1; nr_in = nr; st_in = st;
    n = 0; lat1 = 0; lat2 = 0;
    do begin
      @(posedge clk); #1;
      n++;
      in_valid = poke ? n[0] : 1'b0;
      if (poke) begin st_in = ~st; nr_in = 4'd0; end
      if (out_valid1 && lat1 == 0) lat1 = n;
      if (out_valid2 && lat2 == 0) lat2 = n;
      if (n == 1 && l1 > 1) begin
        chk("in_ready_run", 320'(in_ready1), 320'(1'b0));
        chk("busy_run", 320'(busy1), 320'(1'b1));
      end
    end while ((lat1 == 0 || lat2 == 0) && n < 40);
    exp = exp_q.pop_front();
    chk("latency_u1", 320'(lat1), 320'(l1));
    chk("latency_u2", 320'(lat2), 320'(l2));
    chk("state_u1", st_out1, exp);
    chk("state_u2", st_out2, exp);
    got = st_out1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      in_valid = poke ? ~in_valid : 1'b0;
      chk("hold_valid", 320'({out_valid1, out_valid2}), 320'(2'b11));
      chk("hold_ready", 320'({in_ready1, in_ready2}), 320'(2'b00));
      chk("hold_state_u1", st_out1, exp);
      chk("hold_state_u2", st_out2, exp);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("accept_flags", 320'({out_valid1, out_valid2, in_ready1, in_ready2, busy1, busy2}),
        320'(6'b001100));
  endtask

  typedef struct {
    logic [3:0]   nr;
    logic [319:0] st;
    int           l1;
    int           l2;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [319:0] got, r12;
    int ne;
    logic [3:0] nr;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_flags", 320'({in_ready1, out_valid1, busy1, in_ready2, out_valid2, busy2}),
        320'(6'b100100));
    chk("reset_state_u1", st_out1, '0);
    chk("reset_state_u2", st_out2, '0);
    rst_n = 1'b1;

    // table of vectors; latencies from ceil(nr/UNROLL)+1
    vecs[0] = '{nr: 4'd12, st: {64'h0000080100cc0002, 256'd0}, l1: 13, l2: 7};
    vecs[1] = '{nr: 4'd8,  st: rnd320(), l1: 9,  l2: 5};
    vecs[2] = '{nr: 4'd6,  st: rnd320(), l1: 7,  l2: 4};
    vecs[3] = '{nr: 4'd1,  st: '0,       l1: 2,  l2: 2};
    vecs[4] = '{nr: 4'd0,  st: rnd320(), l1: 1,  l2: 1};
    vecs[5] = '{nr: 4'd15, st: rnd320(), l1: 13, l2: 7};
    vecs[6] = '{nr: 4'd3,  st: rnd320(), l1: 4,  l2: 3};
    vecs[7] = '{nr: 4'd11, st: rnd320(), l1: 12, l2: 7};
    for (int v = 0; v < 8; v++) begin
      run_job(vecs[v].nr, vecs[v].st, vecs[v].l1, vecs[v].l2, 2, 1'b0, got);
      if (v == 4) chk("nr0_passthrough", got, vecs[v].st);
      if (v == 5) begin
        r12 = model_perm(vecs[v].st, 12);
        chk("nr15_equals_nr12", got, r12);
      end
    end

    // backpressure for 20 cycles with requests pulsed during RUN and DONE
    run_job(4'd8, rnd320(), 9, 5, 20, 1'b1, got);

    // back-to-back random jobs
    for (int k = 0; k < 6; k++) begin
      nr = 4'($urandom_range(0, 15));
      ne = (nr > 12) ? 12 : int'(nr);
      run_job(nr, rnd320(), ne + 1, (ne + 1) / 2 + 1, $urandom_range(0, 3), 1'b0, got);
    end

    // reset asserted in the 5th RUN cycle
    @(negedge clk);
    in_valid = 1'b1; nr_in = 4'd12; st_in = rnd320();
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("busy_before_reset", 320'({busy1, busy2}), 320'(2'b11));
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_flags", 320'({in_ready1, out_valid1, busy1, in_ready2, out_valid2, busy2}),
        320'(6'b100100));
    chk("midrun_reset_state_u1", st_out1, '0);
    chk("midrun_reset_state_u2", st_out2, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(4'd6, rnd320(), 7, 4, 1, 1'b0, got);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
